// File: rtl/prewish5k_mask_scheduler.sv
// Press-driven mask queue feeding the blinky loader: captures DIP masks on accepted
// presses, enforces a post-press lockout, and delivers one mask per newmask tick.
module prewish5k_mask_scheduler #(
  parameter int DEPTH          = 4,
  parameter int LOCKOUT_CYCLES = 30000,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic                     i_clk,
  input  logic                     RST_I,
  input  logic                     i_press,
  input  logic [7:0]               dip_switch,
  input  logic                     i_tick,
  input  logic                     ACK_I,
  output logic                     STB_O,
  output logic [7:0]               DAT_O,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_reject,
  output logic                     o_overflow,
  output logic                     o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE = 1'b0, STROBE = 1'b1} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] tmo_cnt;

  logic accept;
  logic pop;
  logic full;
  logic push;

  // Handshake: STB_O rises one cycle after a tick pops the head; DAT_O is stable
  // while STB_O is high; ACK_I seen in STROBE ends the transfer, and ack beats timeout.
  assign accept = i_press && (lock_cnt == '0);
  assign pop    = (state == IDLE) && i_tick && (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign push   = accept && (!full || pop);

  assign o_count = count;

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (!RST_I && push) mem[wr_ptr] <= ~dip_switch;
  end

  always_ff @(posedge i_clk) begin
    if (RST_I) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock_cnt   <= '0;
      tmo_cnt    <= '0;
      STB_O      <= 1'b0;
      DAT_O      <= '0;
      o_reject   <= 1'b0;
      o_overflow <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_reject <= i_press && (lock_cnt != '0);

      if (accept)               lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
      else if (lock_cnt != '0)  lock_cnt <= lock_cnt - 1'b1;

      if (accept && full && !pop) o_overflow <= 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            DAT_O   <= mem[rd_ptr];
            STB_O   <= 1'b1;
            tmo_cnt <= '0;
            state   <= STROBE;
          end
        end
        STROBE: begin
          if (ACK_I) begin
            STB_O <= 1'b0;
            state <= IDLE;
          end else if (tmo_cnt == TW'(ACK_TIMEOUT)) begin
            // Abandon the entry; it has already left the queue.
            STB_O <= 1'b0;
            o_err <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prewish5k_mask_scheduler.sv
// Directed bench for prewish5k_mask_scheduler with short lockout and ack timeout.
module tb_prewish5k_mask_scheduler;

  localparam int DEPTH = 4;
  localparam int LOCK  = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       press = 1'b0;
  logic [7:0] dip = 8'hFF;
  logic       tick = 1'b0;
  logic       ack = 1'b0;
  logic       stb;
  logic [7:0] dat;
  logic [2:0] count;
  logic       reject;
  logic       overflow;
  logic       err;

  int checks = 0;
  int errors = 0;
  int hi_cycles;

  prewish5k_mask_scheduler #(
    .DEPTH(DEPTH), .LOCKOUT_CYCLES(LOCK), .ACK_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .RST_I(rst), .i_press(press), .dip_switch(dip),
    .i_tick(tick), .ACK_I(ack), .STB_O(stb), .DAT_O(dat),
    .o_count(count), .o_reject(reject), .o_overflow(overflow), .o_err(err)
  );

  always #5 clk = ~clk;

  // Advance one edge; observe and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; press = 1'b0; tick = 1'b0; ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One accepted press followed by enough idle cycles for the lockout to clear.
  task automatic press_mask(input logic [7:0] m);
    dip = m; press = 1'b1;
    step();
    press = 1'b0;
    repeat (LOCK - 1) step();
  endtask

  task automatic deliver(input string tag, input logic [7:0] exp_dat);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check({tag, "_stb"}, 32'(stb), 32'd1);
    check({tag, "_dat"}, 32'(dat), 32'(exp_dat));
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, "_stb_low"}, 32'(stb), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_dat", 32'(dat), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_reject", 32'(reject), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Basic press, tick, ack
    dip = 8'b0101_1111; press = 1'b1;
    step();
    press = 1'b0;
    check("basic_count1", 32'(count), 32'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("basic_stb", 32'(stb), 32'd1);
    check("basic_dat", 32'(dat), 32'hA0);
    check("basic_count0", 32'(count), 32'd0);
    step();
    check("basic_stb_hold", 32'(stb), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("basic_stb_drop", 32'(stb), 32'd0);
    check("basic_dat_keep", 32'(dat), 32'hA0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("idle_ack_ignored", 32'(stb), 32'd0);

    // Lockout window: accept at +0, reject at +1 and +3, accept at +4
    do_reset();
    dip = 8'hF0; press = 1'b1;
    step();
    check("lock_accept1", 32'(count), 32'd1);
    step();
    press = 1'b0;
    check("lock_rej1", 32'(reject), 32'd1);
    check("lock_rej1_count", 32'(count), 32'd1);
    step();
    check("lock_rej_pulse_end", 32'(reject), 32'd0);
    press = 1'b1;
    step();
    check("lock_rej2", 32'(reject), 32'd1);
    step();
    press = 1'b0;
    check("lock_accept2_reject", 32'(reject), 32'd0);
    check("lock_accept2_count", 32'(count), 32'd2);

    // Overflow: five presses into a four-deep queue, then ordered drain
    do_reset();
    press_mask(8'hFE);
    press_mask(8'hFD);
    press_mask(8'hFB);
    press_mask(8'hF7);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    press_mask(8'hEF);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    deliver("ovf_d0", 8'h01);
    deliver("ovf_d1", 8'h02);
    deliver("ovf_d2", 8'h04);
    deliver("ovf_d3", 8'h08);
    check("ovf_empty", 32'(count), 32'd0);

    // Full queue: simultaneous press and tick, then wrap-around drain
    do_reset();
    press_mask(8'hFE);
    press_mask(8'hFD);
    press_mask(8'hFB);
    press_mask(8'hF7);
    dip = 8'hEF; press = 1'b1; tick = 1'b1;
    step();
    press = 1'b0; tick = 1'b0;
    check("fullpp_count", 32'(count), 32'd4);
    check("fullpp_overflow", 32'(overflow), 32'd0);
    check("fullpp_stb", 32'(stb), 32'd1);
    check("fullpp_dat", 32'(dat), 32'h01);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("strobe_tick_ignored", 32'(count), 32'd4);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("fullpp_stb_low", 32'(stb), 32'd0);
    deliver("wrap_d1", 8'h02);
    deliver("wrap_d2", 8'h04);
    deliver("wrap_d3", 8'h08);
    deliver("wrap_d4", 8'h10);
    check("wrap_empty", 32'(count), 32'd0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("empty_tick_no_stb", 32'(stb), 32'd0);

    // Ack timeout
    do_reset();
    press_mask(8'hFE);
    press_mask(8'hFD);
    tick = 1'b1;
    step();
    tick = 1'b0;
    hi_cycles = 0;
    while (stb === 1'b1 && hi_cycles < 40) begin
      hi_cycles++;
      step();
    end
    check("tmo_high_cycles", 32'(hi_cycles), 32'd9);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_count", 32'(count), 32'd1);
    deliver("tmo_next", 8'h02);
    check("tmo_err_sticky", 32'(err), 32'd1);

    // Ack arriving on the timeout cycle wins
    do_reset();
    press_mask(8'hFB);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (TMO) step();
    check("ackrace_stb_still", 32'(stb), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ackrace_stb_low", 32'(stb), 32'd0);
    check("ackrace_no_err", 32'(err), 32'd0);

    // Reset during an active strobe with entries still queued
    do_reset();
    press_mask(8'hFE);
    press_mask(8'hFD);
    press_mask(8'hFB);
    press_mask(8'hF7);
    press_mask(8'hEF);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("midrst_pre_stb", 32'(stb), 32'd1);
    check("midrst_pre_count", 32'(count), 32'd3);
    check("midrst_pre_overflow", 32'(overflow), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_stb", 32'(stb), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("midrst_tick_no_stb", 32'(stb), 32'd0);
    step();
    check("midrst_tick_no_stb2", 32'(stb), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
